// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and widths for the line server
package mem_ctrl_pkg;
    localparam int LINE_W = 128;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {G_INS, G_DATA} grant_t;
endpackage

// File: rtl/mem_line_server_if.sv
// rtl/mem_line_server_if.sv - instruction/data cache ports of the line server
interface mem_line_server_if;
    import mem_ctrl_pkg::*;

    logic              ireq_ins;
    logic [31:0]       iaddr_ins;
    logic [LINE_W-1:0] odata_ins;
    logic              ovalid_ins;
    logic              ireq_data;
    logic [31:0]       iaddr_data;
    logic              iwe_data;
    logic [WORD_W-1:0] iwdata_data;
    logic [LINE_W-1:0] odata_data;
    logic              ovalid_data;
    logic              obusy;

    modport slave (
        input  ireq_ins, iaddr_ins, ireq_data, iaddr_data, iwe_data, iwdata_data,
        output odata_ins, ovalid_ins, odata_data, ovalid_data, obusy
    );

    modport master (
        output ireq_ins, iaddr_ins, ireq_data, iaddr_data, iwe_data, iwdata_data,
        input  odata_ins, ovalid_ins, odata_data, ovalid_data, obusy
    );
endinterface

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - single-port line RAM with word write, write-first read
module mem_line_array
    import mem_ctrl_pkg::*;
#(
    parameter int    IDX_W     = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [1:0]        wsel,
    input  logic [WORD_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);
    logic [LINE_W-1:0] mem [2**IDX_W];
    logic [LINE_W-1:0] merged;

    always_comb begin
        merged = mem[idx];
        merged[wsel*WORD_W +: WORD_W] = wdata;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= merged;
            end
            rdata <= we ? merged : mem[idx];
        end
    end
endmodule

// File: rtl/mem_line_server.sv
// rtl/mem_line_server.sv - arbitrated fixed-latency line server for I/D caches
module mem_line_server
    import mem_ctrl_pkg::*;
#(
    parameter int    IDX_W     = 8,
    parameter int    LATENCY   = 4,
    parameter string INIT_FILE = ""
) (
    input  logic clk,
    input  logic rstn,
    mem_line_server_if.slave bus
);
    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    grant_t            last_grant, gnt, pick;
    logic              load, tie, mem_en;
    logic [IDX_W-1:0]  txn_idx;
    logic [1:0]        txn_wsel;
    logic              txn_we;
    logic [WORD_W-1:0] txn_wdata;
    logic [LINE_W-1:0] rdata, ins_hold, data_hold;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{bus.iaddr_ins[31:IDX_W+4], bus.iaddr_ins[1:0],
                                bus.iaddr_data[31:IDX_W+4], bus.iaddr_data[1:0]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        mem_en    = 1'b0;
        tie       = bus.ireq_ins && bus.ireq_data;
        pick      = G_INS;
        if (tie) begin
            pick = (last_grant == G_INS) ? G_DATA : G_INS;
        end else if (bus.ireq_data) begin
            pick = G_DATA;
        end
        case (state)
            IDLE: begin
                if (bus.ireq_ins || bus.ireq_data) begin
                    load      = 1'b1;
                    cnt_nxt   = 4'(LATENCY - 2);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    mem_en    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant only moves on contested grants, so an uncontested grant does not
    // change who wins the next tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= G_INS;
            gnt        <= G_INS;
            txn_idx    <= '0;
            txn_wsel   <= 2'd0;
            txn_we     <= 1'b0;
            txn_wdata  <= '0;
            ins_hold   <= '0;
            data_hold  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                gnt       <= pick;
                txn_idx   <= (pick == G_DATA) ? bus.iaddr_data[IDX_W+3:4] : bus.iaddr_ins[IDX_W+3:4];
                txn_wsel  <= (pick == G_DATA) ? bus.iaddr_data[3:2] : bus.iaddr_ins[3:2];
                txn_we    <= (pick == G_DATA) && bus.iwe_data;
                txn_wdata <= bus.iwdata_data;
                if (tie) begin
                    last_grant <= pick;
                end
            end
            if (state == RESP) begin
                if (gnt == G_INS) begin
                    ins_hold <= rdata;
                end else begin
                    data_hold <= rdata;
                end
            end
        end
    end

    mem_line_array #(
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (txn_we),
        .idx   (txn_idx),
        .wsel  (txn_wsel),
        .wdata (txn_wdata),
        .rdata (rdata)
    );

    // The line is shown straight from the RAM during RESP and held afterwards.
    assign bus.ovalid_ins  = (state == RESP) && (gnt == G_INS);
    assign bus.ovalid_data = (state == RESP) && (gnt == G_DATA);
    assign bus.odata_ins   = bus.ovalid_ins ? rdata : ins_hold;
    assign bus.odata_data  = bus.ovalid_data ? rdata : data_hold;
    assign bus.obusy       = (state != IDLE);
endmodule

// File: tb/tb_mem_line_server.sv
// tb/tb_mem_line_server.sv - directed self-checking bench for mem_line_server
module tb_mem_line_server;
    localparam logic [127:0] L1  = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] L2  = 128'h20000003_20000002_20000001_20000000;
    localparam logic [127:0] L2B = 128'h20000003_DEADBEEF_20000001_20000000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_line_server_if a_if ();
    mem_line_server_if b_if ();

    mem_line_server #(.IDX_W(8), .LATENCY(4)) dut_a (.clk(clk), .rstn(rstn), .bus(a_if));
    mem_line_server #(.IDX_W(8), .LATENCY(2)) dut_b (.clk(clk), .rstn(rstn), .bus(b_if));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input bit on_b, input bit dport, input logic [31:0] addr,
                          input logic we, input logic [31:0] wd, input int exp_lat,
                          input string tag, output logic [127:0] line);
        int lat;
        int other;
        lat   = -1;
        other = 0;
        line  = '0;
        if (on_b) begin
            b_if.ireq_data = dport; b_if.ireq_ins = !dport;
            b_if.iaddr_data = addr; b_if.iaddr_ins = addr;
            b_if.iwe_data = we; b_if.iwdata_data = wd;
        end else begin
            a_if.ireq_data = dport; a_if.ireq_ins = !dport;
            a_if.iaddr_data = addr; a_if.iaddr_ins = addr;
            a_if.iwe_data = we; a_if.iwdata_data = wd;
        end
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            step();
            if (on_b) begin
                if (dport ? b_if.ovalid_data : b_if.ovalid_ins) begin
                    lat = n; line = dport ? b_if.odata_data : b_if.odata_ins;
                end
                if (dport ? b_if.ovalid_ins : b_if.ovalid_data) other++;
            end else begin
                if (dport ? a_if.ovalid_data : a_if.ovalid_ins) begin
                    lat = n; line = dport ? a_if.odata_data : a_if.odata_ins;
                end
                if (dport ? a_if.ovalid_ins : a_if.ovalid_data) other++;
            end
        end
        a_if.ireq_data = 1'b0; a_if.ireq_ins = 1'b0;
        b_if.ireq_data = 1'b0; b_if.ireq_ins = 1'b0;
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_other_valid"}, 128'(other), 128'd0);
        step();
    endtask

    task automatic tie_test(input int exp_ins_lat, input int exp_data_lat, input string tag);
        int li;
        int ld;
        logic [127:0] gi;
        logic [127:0] gd;
        li = -1; ld = -1; gi = '0; gd = '0;
        a_if.ireq_ins = 1'b1;  a_if.iaddr_ins = 32'h10;
        a_if.ireq_data = 1'b1; a_if.iaddr_data = 32'h20; a_if.iwe_data = 1'b0;
        for (int n = 1; n <= 30 && (li < 0 || ld < 0); n++) begin
            step();
            if (a_if.ovalid_ins && li < 0) begin
                li = n; gi = a_if.odata_ins; a_if.ireq_ins = 1'b0;
            end
            if (a_if.ovalid_data && ld < 0) begin
                ld = n; gd = a_if.odata_data; a_if.ireq_data = 1'b0;
            end
        end
        a_if.ireq_ins = 1'b0; a_if.ireq_data = 1'b0;
        check({tag, "_ins_lat"}, 128'(li), 128'(exp_ins_lat));
        check({tag, "_data_lat"}, 128'(ld), 128'(exp_data_lat));
        check({tag, "_ins_line"}, gi, L1);
        check({tag, "_data_line"}, gd, L2B);
        step();
    endtask

    initial begin
        logic [127:0] line;
        int lat;
        int nvalid;
        a_if.ireq_ins = 1'b0; a_if.iaddr_ins = '0; a_if.ireq_data = 1'b0;
        a_if.iaddr_data = '0; a_if.iwe_data = 1'b0; a_if.iwdata_data = '0;
        b_if.ireq_ins = 1'b0; b_if.iaddr_ins = '0; b_if.ireq_data = 1'b0;
        b_if.iaddr_data = '0; b_if.iwe_data = 1'b0; b_if.iwdata_data = '0;
        step(); step();
        check("rst_obusy", 128'(a_if.obusy), 128'd0);
        check("rst_ovalid_ins", 128'(a_if.ovalid_ins), 128'd0);
        check("rst_ovalid_data", 128'(a_if.ovalid_data), 128'd0);
        check("rst_odata_ins", a_if.odata_ins, 128'd0);
        check("rst_odata_data", a_if.odata_data, 128'd0);
        rstn = 1'b1;
        step();

        for (int w = 0; w < 4; w++) begin
            do_txn(1'b0, 1'b1, 32'h10 + 32'(4 * w), 1'b1, {4{8'(w * 8'h11)}}, 4, "wr_l1", line);
        end
        check("wr_l1_ack_line", line, L1);

        do_txn(1'b0, 1'b0, 32'h10, 1'b0, 32'h0, 4, "rd_ins_l1", line);
        check("rd_ins_l1_line", line, L1);
        check("rd_ins_l1_data_held", a_if.odata_data, L1);

        for (int w = 0; w < 4; w++) begin
            do_txn(1'b0, 1'b1, 32'h20 + 32'(4 * w), 1'b1, 32'h20000000 + 32'(w), 4, "wr_l2", line);
        end
        check("wr_l2_ack_line", line, L2);
        do_txn(1'b0, 1'b1, 32'h28, 1'b1, 32'hDEADBEEF, 4, "wr_beef", line);
        check("wr_beef_ack_line", line, L2B);
        do_txn(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 4, "rd_l2", line);
        check("rd_l2_line", line, L2B);
        check("rd_l2_ins_held", a_if.odata_ins, L1);

        tie_test(9, 4, "tie1");
        tie_test(4, 9, "tie2");

        do_txn(1'b0, 1'b1, 32'h0, 1'b1, 32'hA5A5A5A5, 4, "wr_alias", line);
        check("wr_alias_w0", 128'(line[31:0]), 128'h A5A5A5A5);
        do_txn(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 4, "rd_alias", line);
        check("rd_alias_w0", 128'(line[31:0]), 128'hA5A5A5A5);

        lat = -1; nvalid = 0;
        a_if.ireq_ins = 1'b1; a_if.iaddr_ins = 32'h10;
        for (int n = 1; n <= 15; n++) begin
            step();
            if (n == 1) a_if.ireq_ins = 1'b0;
            if (a_if.ovalid_ins) begin
                nvalid++;
                if (lat < 0) lat = n;
            end
        end
        check("drop_lat", 128'(lat), 128'd4);
        check("drop_nvalid", 128'(nvalid), 128'd1);
        check("drop_obusy_end", 128'(a_if.obusy), 128'd0);

        a_if.ireq_data = 1'b1; a_if.iaddr_data = 32'h10;
        a_if.iwe_data = 1'b1; a_if.iwdata_data = 32'h12345678;
        step();
        a_if.ireq_data = 1'b0;
        step();
        rstn = 1'b0;
        #1;
        check("rstmid_obusy", 128'(a_if.obusy), 128'd0);
        check("rstmid_ovalid", 128'(a_if.ovalid_data), 128'd0);
        step();
        rstn = 1'b1;
        nvalid = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (a_if.ovalid_data || a_if.ovalid_ins) nvalid++;
        end
        check("rstmid_no_pulse", 128'(nvalid), 128'd0);
        check("rstmid_odata_cleared", a_if.odata_data, 128'd0);
        do_txn(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 4, "rd_after_rst", line);
        check("rd_after_rst_line", line, L1);

        do_txn(1'b1, 1'b1, 32'h40, 1'b1, 32'hCAFEF00D, 2, "b_wr", line);
        check("b_wr_w0", 128'(line[31:0]), 128'hCAFEF00D);
        do_txn(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 2, "b_rd_ins", line);
        check("b_rd_ins_w0", 128'(line[31:0]), 128'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
